// File: rtl/tl_source_shrinker.sv
// TileLink UL/UH source-ID shrinker: maps wide host source IDs onto a small pool of
// device-side slots and restores the original ID on the D channel.

module tl_burst_tracker #(
    parameter int DataWidth = 64,
    parameter int MaxSize   = 6,
    localparam int SizeWidth = $clog2(MaxSize + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 a_valid,
    input  logic                 a_ready,
    input  logic [2:0]           a_opcode,
    input  logic [SizeWidth-1:0] a_size,
    input  logic                 d_valid,
    input  logic                 d_ready,
    input  logic [2:0]           d_opcode,
    input  logic [SizeWidth-1:0] d_size,
    output logic                 req_first,
    output logic                 req_last,
    output logic                 gnt_first,
    output logic                 gnt_last
);

    localparam int BeatLog2 = $clog2(DataWidth / 8);
    localparam int CntW     = MaxSize + 1;

    function automatic logic [CntW-1:0] num_beats(input logic has_data,
                                                  input logic [SizeWidth-1:0] size);
        if (!has_data || int'(size) <= BeatLog2) return CntW'(1);
        return CntW'(1) << (int'(size) - BeatLog2);
    endfunction

    // Counters hold the beats still to come in the current burst; zero means idle.
    logic [CntW-1:0] a_cnt_q, d_cnt_q;
    logic [CntW-1:0] a_beats, d_beats;
    logic            a_fire, d_fire;

    // Get/Intent carry no data; AccessAckData is the only data-bearing D opcode here.
    assign a_beats = num_beats(!a_opcode[2], a_size);
    assign d_beats = num_beats(d_opcode == 3'd1, d_size);
    assign a_fire  = a_valid & a_ready;
    assign d_fire  = d_valid & d_ready;

    assign req_first = (a_cnt_q == '0);
    assign req_last  = req_first ? (a_beats == CntW'(1)) : (a_cnt_q == CntW'(1));
    assign gnt_first = (d_cnt_q == '0);
    assign gnt_last  = gnt_first ? (d_beats == CntW'(1)) : (d_cnt_q == CntW'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_cnt_q <= '0;
            d_cnt_q <= '0;
        end else begin
            if (a_fire) begin
                if (req_last)       a_cnt_q <= '0;
                else if (req_first) a_cnt_q <= a_beats - CntW'(1);
                else                a_cnt_q <= a_cnt_q - CntW'(1);
            end
            if (d_fire) begin
                if (gnt_last)       d_cnt_q <= '0;
                else if (gnt_first) d_cnt_q <= d_beats - CntW'(1);
                else                d_cnt_q <= d_cnt_q - CntW'(1);
            end
        end
    end

endmodule

module tl_source_shrinker #(
    parameter int DataWidth         = 64,
    parameter int AddrWidth         = 56,
    parameter int HostSourceWidth   = 4,
    parameter int DeviceSourceWidth = 1,
    parameter int SinkWidth         = 1,
    parameter int MaxSize           = 6,
    localparam int SizeWidth = $clog2(MaxSize + 1),
    localparam int MaskWidth = DataWidth / 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    // host side A (requests in)
    input  logic                         host_a_valid,
    output logic                         host_a_ready,
    input  logic [2:0]                   host_a_opcode,
    input  logic [2:0]                   host_a_param,
    input  logic [SizeWidth-1:0]         host_a_size,
    input  logic [HostSourceWidth-1:0]   host_a_source,
    input  logic [AddrWidth-1:0]         host_a_address,
    input  logic [MaskWidth-1:0]         host_a_mask,
    input  logic [DataWidth-1:0]         host_a_data,
    input  logic                         host_a_corrupt,
    // host side D (responses out)
    output logic                         host_d_valid,
    input  logic                         host_d_ready,
    output logic [2:0]                   host_d_opcode,
    output logic [1:0]                   host_d_param,
    output logic [SizeWidth-1:0]         host_d_size,
    output logic [HostSourceWidth-1:0]   host_d_source,
    output logic [SinkWidth-1:0]         host_d_sink,
    output logic                         host_d_denied,
    output logic [DataWidth-1:0]         host_d_data,
    output logic                         host_d_corrupt,
    // host side B/C/E tie-offs
    output logic                         host_b_valid,
    input  logic                         host_b_ready,
    input  logic                         host_c_valid,
    output logic                         host_c_ready,
    input  logic                         host_e_valid,
    output logic                         host_e_ready,
    // device side A (requests out)
    output logic                         device_a_valid,
    input  logic                         device_a_ready,
    output logic [2:0]                   device_a_opcode,
    output logic [2:0]                   device_a_param,
    output logic [SizeWidth-1:0]         device_a_size,
    output logic [DeviceSourceWidth-1:0] device_a_source,
    output logic [AddrWidth-1:0]         device_a_address,
    output logic [MaskWidth-1:0]         device_a_mask,
    output logic [DataWidth-1:0]         device_a_data,
    output logic                         device_a_corrupt,
    // device side D (responses in)
    input  logic                         device_d_valid,
    output logic                         device_d_ready,
    input  logic [2:0]                   device_d_opcode,
    input  logic [1:0]                   device_d_param,
    input  logic [SizeWidth-1:0]         device_d_size,
    input  logic [DeviceSourceWidth-1:0] device_d_source,
    input  logic [SinkWidth-1:0]         device_d_sink,
    input  logic                         device_d_denied,
    input  logic [DataWidth-1:0]         device_d_data,
    input  logic                         device_d_corrupt,
    // device side B/C/E tie-offs
    input  logic                         device_b_valid,
    output logic                         device_b_ready,
    output logic                         device_c_valid,
    input  logic                         device_c_ready,
    output logic                         device_e_valid,
    input  logic                         device_e_ready
);

    localparam int NumSlots = 2 ** DeviceSourceWidth;

    if (HostSourceWidth <= DeviceSourceWidth) begin : g_bad_width
        $fatal(1, "tl_source_shrinker: HostSourceWidth must exceed DeviceSourceWidth");
    end

    logic [NumSlots-1:0]          busy_q, busy_next;
    logic [HostSourceWidth-1:0]   src_q [NumSlots];
    logic [DeviceSourceWidth-1:0] burst_slot_q;
    logic [DeviceSourceWidth-1:0] free_slot;
    logic                         none_free;
    logic                         req_first, req_last, gnt_first, gnt_last;
    logic                         a_stall, alloc, d_free;
    logic                         unused_tieoff;

    tl_burst_tracker #(
        .DataWidth (DataWidth),
        .MaxSize   (MaxSize)
    ) u_burst_tracker (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .a_valid   (host_a_valid),
        .a_ready   (host_a_ready),
        .a_opcode  (host_a_opcode),
        .a_size    (host_a_size),
        .d_valid   (host_d_valid),
        .d_ready   (host_d_ready),
        .d_opcode  (host_d_opcode),
        .d_size    (host_d_size),
        .req_first (req_first),
        .req_last  (req_last),
        .gnt_first (gnt_first),
        .gnt_last  (gnt_last)
    );

    // Lowest idle slot, from registered state only: a slot freed this cycle is
    // not offered until the next one.
    always_comb begin
        free_slot = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_slot = DeviceSourceWidth'(i);
        end
    end
    assign none_free = &busy_q;

    // Only first beats need a fresh slot; later beats reuse the burst's slot.
    assign a_stall          = req_first & none_free;
    assign device_a_valid   = host_a_valid & ~a_stall;
    assign host_a_ready     = device_a_ready & ~a_stall;
    assign device_a_source  = req_first ? free_slot : burst_slot_q;
    assign device_a_opcode  = host_a_opcode;
    assign device_a_param   = host_a_param;
    assign device_a_size    = host_a_size;
    assign device_a_address = host_a_address;
    assign device_a_mask    = host_a_mask;
    assign device_a_data    = host_a_data;
    assign device_a_corrupt = host_a_corrupt;

    assign host_d_valid   = device_d_valid;
    assign device_d_ready = host_d_ready;
    assign host_d_opcode  = device_d_opcode;
    assign host_d_param   = device_d_param;
    assign host_d_size    = device_d_size;
    assign host_d_source  = src_q[device_d_source];
    assign host_d_sink    = device_d_sink;
    assign host_d_denied  = device_d_denied;
    assign host_d_data    = device_d_data;
    assign host_d_corrupt = device_d_corrupt;

    assign host_b_valid   = 1'b0;
    assign host_c_ready   = 1'b0;
    assign host_e_ready   = 1'b0;
    assign device_b_ready = 1'b1;
    assign device_c_valid = 1'b0;
    assign device_e_valid = 1'b0;
    assign unused_tieoff  = ^{host_b_ready, host_c_valid, host_e_valid,
                              device_b_valid, device_c_ready, device_e_ready, gnt_first};

    assign alloc  = host_a_valid & host_a_ready & req_first;
    assign d_free = device_d_valid & device_d_ready & gnt_last;

    // A freeing slot is always busy, so it never collides with the allocated slot.
    always_comb begin
        busy_next = busy_q;
        if (d_free) busy_next[device_d_source] = 1'b0;
        if (alloc)  busy_next[free_slot] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= busy_next;
    end

    always_ff @(posedge clk_i) begin
        if (alloc) begin
            src_q[free_slot] <= host_a_source;
            if (!req_last) burst_slot_q <= free_slot;
        end
    end

`ifndef SYNTHESIS
    d_slot_busy_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        device_d_valid |-> busy_q[device_d_source]);
    host_c_idle_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !host_c_valid);
    host_e_idle_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !host_e_valid);
    device_b_idle_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !device_b_valid);
`endif

endmodule

// File: doc/tl_source_shrinker.md
# tl_source_shrinker

Narrows the TileLink source ID space between a host with many source IDs and a device that supports few, for example after the data upsizer has widened source. Each first-beat A request is assigned the lowest free device-side source slot, and the original host source is recorded in a slot table. On D responses the original source is restored, and the slot is freed on the last D beat. A and D data pass through combinationally with zero added latency. The block serves TL-UL/TL-UH links only; B, C and E are tied off.

## Interface
- DataWidth, 64: data width on both sides.
- AddrWidth, 56: address width.
- HostSourceWidth, 4: source width on the host side.
- DeviceSourceWidth, 1: source width on the device side; the slot count is N = 2**DeviceSourceWidth. HostSourceWidth <= DeviceSourceWidth is a fatal elaboration error.
- SinkWidth, 1: sink width, passed through.
- MaxSize, 6: log2 of the maximum transfer size in bytes, used for burst tracking.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: asynchronous active-low reset.
- host_a_valid/ready/host_a: device-facing A port from the host, host source width.
- host_d_valid/ready/host_d: device-facing D port to the host.
- host_b*, host_c*, host_e*: present for port-macro compatibility.
  - host_b_valid is driven 0.
  - host_c_ready and host_e_ready are driven 0.
- device_a_valid/ready/device_a: host-facing A port to the device, device source width.
- device_d_valid/ready/device_d: host-facing D port from the device.
- device_b*, device_c*, device_e*:
  - device_b_ready is driven 1.
  - device_c_valid and device_e_valid are driven 0.

## Operation
- State is held per slot i:
  - busy_q[i], 1 bit.
  - src_q[i], HostSourceWidth bits.
- A tl_burst_tracker is instantiated on the host side to provide req_first/req_last and gnt_first/gnt_last.
- Free-slot selection:
  - Lowest index i with busy_q[i]==0; none_free is 1 when all slots are busy.
  - Selection uses only registered busy_q, so a slot freed in cycle t is not reusable until t+1.
- A channel, first beat:
  - If none_free, drive device_a_valid=0 and host_a_ready=0.
  - Otherwise device_a_valid=host_a_valid, host_a_ready=device_a_ready, and device_a.source is the selected slot.
  - On the handshake, set busy_q[slot]=1 and src_q[slot]=host_a.source.
  - For a multi-beat request, latch the slot into burst_slot_q.
- A channel, subsequent beats of a burst: device_a.source=burst_slot_q, with no stall on none_free.
- A channel, other fields: opcode, param, size, address, mask, data and corrupt pass through unchanged.
- D channel:
  - host_d.source = src_q[device_d.source]; all other fields pass through.
  - valid and ready connect directly.
  - On a last-beat D handshake, clear busy_q[device_d.source].
- Simultaneous events:
  - An A first-beat allocation of slot j and a D last-beat free of slot k in the same cycle both take effect; j != k is guaranteed because slot k is busy.
- Protocol errors, simulation assertions only:
  - D response with a busy_q==0 slot.
  - host_c_valid or host_e_valid asserted.
  - device_b_valid asserted.

## Timing
- A and D paths are combinational; added latency is 0 cycles.
- State updates on the clk_i rising edge; the free-to-reuse bubble is exactly 1 cycle.
- Reset, asynchronous on rst_ni low:
  - All busy_q=0 and burst state cleared; src_q and burst_slot_q are don't-care.
  - During and after reset: device_a_valid=0 until host_a_valid, and host_d_valid mirrors device_d_valid.
  - Tie-off outputs hold their constant values.
- Reset mid-operation discards all outstanding mappings. The surrounding system must reset the device in the same cycle.
- Handshake rules:
  - host_a_ready never depends on device_d_*.
  - device_d_ready == host_d_ready, so no D-to-D combinational loop is introduced beyond passthrough.
  - A valid rule: device_a_valid may only drop after a handshake, i.e. none_free cannot assert mid-offer. This holds because slots are freed only by D and allocated only by A.

## Test plan
- N=2, HostSourceWidth=4:
  - Get source 9 → device_a.source=0.
  - Get source 3 → device_a.source=1.
  - Third Get source 5 → host_a_ready=0 until a D response on slot 0 completes, then accepted one cycle later with source 0.
- D for slot 1 returning AccessAckData → host_d.source=3 and busy_q[1] cleared after the handshake.
- PutFullData, size 6, DataWidth 64 (8 beats), source 7:
  - All 8 beats carry device source 0.
  - A D response for another slot mid-burst does not change the burst source.
- Same-cycle free of slot 0 and first-beat allocation with slot 1 free → allocation gets slot 1 and slot 0 is free next cycle.
- Assert rst_ni low with both slots busy → next Get source 2 receives device source 0 with no stall.
- Random 10k-transaction run with response reordering by device slot → every host_d.source matches its originating request and no slot leaks.
